// File: rtl/tjmono2_rx_align_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tjmono2_rx_align_ctrl_if
// Brief    : Register bus between the RX alignment sequencer and one RX core.
// Revision : 1.0 - initial release
// ============================================================================
interface tjmono2_rx_align_ctrl_if #(
  parameter int ABUSWIDTH = 32
);
  logic [ABUSWIDTH-1:0] M_BUS_ADD;
  logic [7:0]           M_BUS_DATA_OUT;
  logic [7:0]           M_BUS_DATA_IN;
  logic                 M_BUS_WR;
  logic                 M_BUS_RD;

  modport master (
    output M_BUS_ADD,
    output M_BUS_DATA_OUT,
    output M_BUS_WR,
    output M_BUS_RD,
    input  M_BUS_DATA_IN
  );

  modport slave (
    input  M_BUS_ADD,
    input  M_BUS_DATA_OUT,
    input  M_BUS_WR,
    input  M_BUS_RD,
    output M_BUS_DATA_IN
  );
endinterface
`default_nettype wire

// File: rtl/tjmono2_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tjmono2_rx_align_ctrl
// Brief    : Sweeps RX sampling edge/delay, applies centre of widest passing
//            window. Optional per-tap pass map: define RX_ALIGN_PASS_MAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tjmono2_rx_align_ctrl #(
  parameter int ABUSWIDTH     = 32,
  parameter int DLY_STEPS     = 32,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MIN_WINDOW    = 3
) (
  input  wire                        BUS_CLK,
  input  wire                        BUS_RST,
  input  wire                        START,
  input  wire                        CONF_INVERT,
  input  wire                        CONF_NO_8B10B,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       FAIL,
  output logic [4:0]                 BEST_DLY,
  output logic                       BEST_EDGE,
  tjmono2_rx_align_ctrl_if.master    bus,
  output logic [2*DLY_STEPS-1:0]     PASS_MAP
);

  localparam int c_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0] c_LAST_DLY   = 5'(DLY_STEPS - 1);
  localparam logic [5:0] c_MIN_WINDOW = 6'(MIN_WINDOW);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RST_WR   = 4'd1,
    S_CFG_WR   = 4'd2,
    S_EN_WR    = 4'd3,
    S_SETTLE   = 4'd4,
    S_RD_RDY   = 4'd5,
    S_RD_RDY_W = 4'd6,
    S_RD_ERR   = 4'd7,
    S_RD_ERR_W = 4'd8,
    S_EVAL     = 4'd9,
    S_A_RST    = 4'd10,
    S_A_CFG    = 4'd11,
    S_A_EN     = 4'd12
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_edge;
  logic [4:0]           r_dly;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_ready;
  logic [7:0]           r_err;
  logic [5:0]           r_run_len;
  logic [4:0]           r_run_start;
  logic [5:0]           r_best_len;
  logic [4:0]           r_best_start;
  logic                 r_best_edge;

  logic                 w_pass;
  logic                 w_last_dly;
  logic [5:0]           w_run_len_inc;
  logic [5:0]           w_cand_len;
  logic [4:0]           w_cand_start;
  logic                 w_run_end;
  logic                 w_ok;
  logic [4:0]           w_center;
  logic [7:0]           w_en_data;
  logic                 w_wr;
  logic                 w_rd;
  logic [ABUSWIDTH-1:0] w_add;
  logic [7:0]           w_data;

  assign w_pass        = r_ready && (r_err == 8'd0);
  assign w_last_dly    = (r_dly == c_LAST_DLY);
  assign w_run_len_inc = r_run_len + 6'd1;
  assign w_cand_len    = w_pass ? w_run_len_inc : r_run_len;
  assign w_cand_start  = (w_pass && (r_run_len == 6'd0)) ? r_dly : r_run_start;
  // A run is closed by a failing tap or by the end of the delay range of an edge.
  assign w_run_end     = !w_pass || w_last_dly;
  assign w_ok          = (r_best_len >= c_MIN_WINDOW);
  assign w_center      = r_best_start + 5'((r_best_len - 6'd1) >> 1);
  assign w_en_data     = {5'b0, 1'b1, CONF_INVERT, 1'b0};

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_state      <= S_IDLE;
      r_edge       <= 1'b0;
      r_dly        <= 5'd0;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_err        <= 8'd0;
      r_run_len    <= 6'd0;
      r_run_start  <= 5'd0;
      r_best_len   <= 6'd0;
      r_best_start <= 5'd0;
      r_best_edge  <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      FAIL         <= 1'b0;
      BEST_DLY     <= 5'd0;
      BEST_EDGE    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            DONE         <= 1'b0;
            FAIL         <= 1'b0;
            BUSY         <= 1'b1;
            r_edge       <= 1'b0;
            r_dly        <= 5'd0;
            r_run_len    <= 6'd0;
            r_run_start  <= 5'd0;
            r_best_len   <= 6'd0;
            r_best_start <= 5'd0;
            r_best_edge  <= 1'b0;
          end
        end
        S_EN_WR:    r_cnt   <= '0;
        S_SETTLE:   r_cnt   <= r_cnt + 1'b1;
        S_RD_RDY_W: r_ready <= bus.M_BUS_DATA_IN[0];
        S_RD_ERR_W: r_err   <= bus.M_BUS_DATA_IN;
        S_EVAL: begin
          if (w_run_end && (w_cand_len > r_best_len)) begin
            r_best_len   <= w_cand_len;
            r_best_start <= w_cand_start;
            r_best_edge  <= r_edge;
          end
          r_run_len   <= (w_pass && !w_last_dly) ? w_run_len_inc : 6'd0;
          r_run_start <= w_cand_start;
          if (w_last_dly) begin
            r_dly  <= 5'd0;
            r_edge <= 1'b1;
          end else begin
            r_dly  <= r_dly + 5'd1;
          end
        end
        S_A_RST: begin
          BEST_DLY  <= w_ok ? w_center : 5'd0;
          BEST_EDGE <= w_ok ? r_best_edge : 1'b0;
        end
        S_A_EN: begin
          BUSY <= 1'b0;
          DONE <= w_ok;
          FAIL <= !w_ok;
        end
        default: ;
      endcase
    end
  end

  // Strobes, address and data are decoded from the state so they drop to zero
  // the cycle after a reset, with no bus activity outside the strobe states.
  always_comb begin
    w_next_state = r_state;
    w_wr         = 1'b0;
    w_rd         = 1'b0;
    w_add        = '0;
    w_data       = 8'd0;
    case (r_state)
      S_IDLE:     if (START) w_next_state = S_RST_WR;
      S_RST_WR: begin
        w_wr = 1'b1;
        w_next_state = S_CFG_WR;
      end
      S_CFG_WR: begin
        w_wr   = 1'b1;
        w_add  = ABUSWIDTH'(7);
        w_data = {1'b0, CONF_NO_8B10B, r_edge, r_dly};
        w_next_state = S_EN_WR;
      end
      S_EN_WR: begin
        w_wr   = 1'b1;
        w_add  = ABUSWIDTH'(2);
        w_data = w_en_data;
        w_next_state = S_SETTLE;
      end
      S_SETTLE:   if (r_cnt == c_SETTLE_LAST) w_next_state = S_RD_RDY;
      S_RD_RDY: begin
        w_rd  = 1'b1;
        w_add = ABUSWIDTH'(2);
        w_next_state = S_RD_RDY_W;
      end
      S_RD_RDY_W: w_next_state = S_RD_ERR;
      S_RD_ERR: begin
        w_rd  = 1'b1;
        w_add = ABUSWIDTH'(5);
        w_next_state = S_RD_ERR_W;
      end
      S_RD_ERR_W: w_next_state = S_EVAL;
      S_EVAL:     w_next_state = (r_edge && w_last_dly) ? S_A_RST : S_RST_WR;
      S_A_RST: begin
        w_wr = 1'b1;
        w_next_state = S_A_CFG;
      end
      S_A_CFG: begin
        w_wr   = 1'b1;
        w_add  = ABUSWIDTH'(7);
        w_data = {1'b0, CONF_NO_8B10B, BEST_EDGE, BEST_DLY};
        w_next_state = S_A_EN;
      end
      S_A_EN: begin
        w_wr   = 1'b1;
        w_add  = ABUSWIDTH'(2);
        w_data = w_en_data;
        w_next_state = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  assign bus.M_BUS_WR       = w_wr;
  assign bus.M_BUS_RD       = w_rd;
  assign bus.M_BUS_ADD      = w_add;
  assign bus.M_BUS_DATA_OUT = w_data;

`ifdef RX_ALIGN_PASS_MAP_EN
  logic [2*DLY_STEPS-1:0] r_pass_map;
  logic [6:0]             w_map_idx;

  assign w_map_idx = r_edge ? (7'(DLY_STEPS) + {2'b0, r_dly}) : {2'b0, r_dly};

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_pass_map <= '0;
    end else if ((r_state == S_IDLE) && START) begin
      r_pass_map <= '0;
    end else if (r_state == S_EVAL) begin
      for (int i = 0; i < 2*DLY_STEPS; i++) begin
        if (w_map_idx == 7'(i)) r_pass_map[i] <= w_pass;
      end
    end
  end

  assign PASS_MAP = r_pass_map;
`else
  assign PASS_MAP = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tjmono2_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tjmono2_rx_align_ctrl
// Brief    : Directed bench for the RX alignment sequencer with an RX core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tjmono2_rx_align_ctrl;
  localparam int ABW         = 32;
  localparam int STEPS       = 32;
  localparam int SETTLE      = 4;
  localparam int MINW        = 3;
  localparam int SCAN_CYCLES = 2*STEPS*(SETTLE+8) + 3;
  localparam int LIMIT       = SCAN_CYCLES + 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic conf_inv = 1'b0;
  logic conf_no8 = 1'b0;
  logic busy, done, fail, best_edge;
  logic [4:0] best_dly;
  logic [2*STEPS-1:0] pass_map;

  int n_checks = 0;
  int n_fail = 0;

  tjmono2_rx_align_ctrl_if #(.ABUSWIDTH(ABW)) bus();

  tjmono2_rx_align_ctrl #(
    .ABUSWIDTH(ABW), .DLY_STEPS(STEPS), .SETTLE_CYCLES(SETTLE), .MIN_WINDOW(MINW)
  ) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .START(start),
    .CONF_INVERT(conf_inv), .CONF_NO_8B10B(conf_no8),
    .BUSY(busy), .DONE(done), .FAIL(fail),
    .BEST_DLY(best_dly), .BEST_EDGE(best_edge),
    .bus(bus), .PASS_MAP(pass_map)
  );

  always #5 clk = ~clk;

  // RX core model: pass pattern selected by the last addr7 write
  logic [31:0] pass0 = '0, pass1 = '0;
  logic rdy_all = 1'b0;
  logic [7:0] err_val = 8'd0;
  logic m_edge = 1'b0;
  logic [4:0] m_dly = 5'd0;
  logic tap_pass;
  assign tap_pass = m_edge ? pass1[m_dly] : pass0[m_dly];

  always @(posedge clk) begin
    if (rst) bus.M_BUS_DATA_IN <= 8'd0;
    else if (bus.M_BUS_RD) begin
      if (bus.M_BUS_ADD == 2) bus.M_BUS_DATA_IN <= {7'b0, rdy_all | tap_pass};
      else if (bus.M_BUS_ADD == 5) bus.M_BUS_DATA_IN <= tap_pass ? 8'd0 : err_val;
      else bus.M_BUS_DATA_IN <= 8'd0;
    end
    if (bus.M_BUS_WR && bus.M_BUS_ADD == 7) begin
      m_edge <= bus.M_BUS_DATA_OUT[5];
      m_dly  <= bus.M_BUS_DATA_OUT[4:0];
    end
  end

  // Bus monitor
  int wr_cnt = 0, rd_cnt = 0, cfg_cnt = 0, cfg_bad = 0, en_bad = 0, idle_bad = 0;
  logic [7:0] cfg_log [0:1023];
  logic [ABW-1:0] h_addr [0:2];
  logic [7:0] h_data [0:2];

  always @(negedge clk) begin
    if (bus.M_BUS_WR === 1'b1) begin
      wr_cnt++;
      h_addr[0] = h_addr[1]; h_data[0] = h_data[1];
      h_addr[1] = h_addr[2]; h_data[1] = h_data[2];
      h_addr[2] = bus.M_BUS_ADD; h_data[2] = bus.M_BUS_DATA_OUT;
      if (bus.M_BUS_ADD == 7) begin
        cfg_log[cfg_cnt % 1024] = bus.M_BUS_DATA_OUT;
        cfg_cnt++;
        if (bus.M_BUS_DATA_OUT[7] !== 1'b0 || bus.M_BUS_DATA_OUT[6] !== conf_no8) cfg_bad++;
      end
      if (bus.M_BUS_ADD == 2 && bus.M_BUS_DATA_OUT !== {5'b0, 1'b1, conf_inv, 1'b0}) en_bad++;
    end
    if (bus.M_BUS_RD === 1'b1) rd_cnt++;
    if (bus.M_BUS_WR !== 1'b1 && bus.M_BUS_RD !== 1'b1 &&
        (bus.M_BUS_ADD !== '0 || bus.M_BUS_DATA_OUT !== 8'd0)) idle_bad++;
    if (bus.M_BUS_WR === 1'b1 && bus.M_BUS_RD === 1'b1) idle_bad++;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic set_pattern(input logic [31:0] p0, input logic [31:0] p1,
                             input logic ra, input logic [7:0] ev);
    pass0 = p0; pass1 = p1; rdy_all = ra; err_val = ev;
  endtask

  // START pulse, then count BUSY cycles; optionally re-pulse START mid-scan
  task automatic run_scan(input int restart_at, output int cycles,
                          output logic [2*STEPS-1:0] map_at_start);
    start = 1'b1;
    tick;
    start = 1'b0;
    map_at_start = pass_map;
    cycles = 0;
    while (busy === 1'b1 && cycles < LIMIT) begin
      cycles++;
      start = (cycles == restart_at);
      tick;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0 || fail !== 1'b0) begin n_fail++; $display("FAIL reset_done_fail: got %b%b want 00", done, fail); end
    n_checks++; if (best_dly !== 5'd0 || best_edge !== 1'b0) begin n_fail++; $display("FAIL reset_best: got %0d/%b want 0/0", best_dly, best_edge); end
    n_checks++; if (bus.M_BUS_WR !== 1'b0 || bus.M_BUS_RD !== 1'b0 || bus.M_BUS_ADD !== '0 || bus.M_BUS_DATA_OUT !== 8'd0) begin
      n_fail++; $display("FAIL reset_bus: got wr=%b rd=%b add=%h data=%h want all 0", bus.M_BUS_WR, bus.M_BUS_RD, bus.M_BUS_ADD, bus.M_BUS_DATA_OUT); end
    n_checks++; if (pass_map !== '0) begin n_fail++; $display("FAIL reset_map: got %h want 0", pass_map); end
    rst = 1'b0;
    tick;
    n_checks++; if (busy !== 1'b0 || bus.M_BUS_WR !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b wr=%b want 0/0", busy, bus.M_BUS_WR); end
  endtask

  task automatic test_single_window;
    int cyc, w0, r0, c0, cb0, eb0, ib0;
    logic [2*STEPS-1:0] m0;
    set_pattern(32'h0003_FC00, 32'h0, 1'b0, 8'd0);
    w0 = wr_cnt; r0 = rd_cnt; c0 = cfg_cnt; cb0 = cfg_bad; eb0 = en_bad; ib0 = idle_bad;
    run_scan(0, cyc, m0);
    n_checks++; if (cyc !== SCAN_CYCLES) begin n_fail++; $display("FAIL t1_busy_cycles: got %0d want %0d", cyc, SCAN_CYCLES); end
    n_checks++; if (done !== 1'b1 || fail !== 1'b0) begin n_fail++; $display("FAIL t1_done_fail: got %b%b want 10", done, fail); end
    n_checks++; if (best_dly !== 5'd13 || best_edge !== 1'b0) begin n_fail++; $display("FAIL t1_best: got %0d/%b want 13/0", best_dly, best_edge); end
    n_checks++; if (h_addr[0] !== 0 || h_data[0] !== 8'h00 || h_addr[1] !== 7 || h_data[1] !== 8'h0D || h_addr[2] !== 2 || h_data[2] !== 8'h04) begin
      n_fail++; $display("FAIL t1_final_writes: got %0d:%h %0d:%h %0d:%h want 0:00 7:0d 2:04", h_addr[0], h_data[0], h_addr[1], h_data[1], h_addr[2], h_data[2]); end
    n_checks++; if (wr_cnt - w0 !== 195 || rd_cnt - r0 !== 128) begin n_fail++; $display("FAIL t1_strobe_counts: got wr=%0d rd=%0d want 195/128", wr_cnt - w0, rd_cnt - r0); end
    n_checks++; if (cfg_log[c0 % 1024] !== 8'h00 || cfg_log[(c0+31) % 1024] !== 8'h1F || cfg_log[(c0+32) % 1024] !== 8'h20) begin
      n_fail++; $display("FAIL t1_tap_order: got %h %h %h want 00 1f 20", cfg_log[c0 % 1024], cfg_log[(c0+31) % 1024], cfg_log[(c0+32) % 1024]); end
    n_checks++; if (cfg_bad != cb0 || en_bad != eb0 || idle_bad != ib0) begin n_fail++; $display("FAIL t1_bus_format: got cfg=%0d en=%0d idle=%0d want 0", cfg_bad-cb0, en_bad-eb0, idle_bad-ib0); end
`ifdef RX_ALIGN_PASS_MAP_EN
    n_checks++; if (pass_map !== 64'h0000_0000_0003_FC00) begin n_fail++; $display("FAIL t1_map: got %h want 3fc00", pass_map); end
`else
    n_checks++; if (pass_map !== '0) begin n_fail++; $display("FAIL t1_map: got %h want 0", pass_map); end
`endif
  endtask

  task automatic test_edge1_window;
    int cyc;
    logic [2*STEPS-1:0] m0;
    set_pattern(32'h0000_0070, 32'h0FF0_0000, 1'b1, 8'h80);
    run_scan(0, cyc, m0);
    n_checks++; if (m0 !== '0) begin n_fail++; $display("FAIL t2_map_cleared_on_start: got %h want 0", m0); end
    n_checks++; if (done !== 1'b1 || best_edge !== 1'b1 || best_dly !== 5'd23) begin n_fail++; $display("FAIL t2_best: got done=%b %0d/%b want 1 23/1", done, best_dly, best_edge); end
    n_checks++; if (h_addr[1] !== 7 || h_data[1] !== 8'h37) begin n_fail++; $display("FAIL t2_final_cfg: got %0d:%h want 7:37", h_addr[1], h_data[1]); end
`ifdef RX_ALIGN_PASS_MAP_EN
    n_checks++; if (pass_map !== 64'h0FF0_0000_0000_0070) begin n_fail++; $display("FAIL t2_map: got %h want 0ff0000000000070", pass_map); end
`else
    n_checks++; if (pass_map !== '0) begin n_fail++; $display("FAIL t2_map: got %h want 0", pass_map); end
`endif
  endtask

  task automatic test_tie;
    int cyc;
    logic [2*STEPS-1:0] m0;
    set_pattern(32'h0000_003C, 32'h0000_003C, 1'b1, 8'h01);
    run_scan(0, cyc, m0);
    n_checks++; if (done !== 1'b1 || best_edge !== 1'b0 || best_dly !== 5'd3) begin n_fail++; $display("FAIL t3_tie: got done=%b %0d/%b want 1 3/0", done, best_dly, best_edge); end
    n_checks++; if (h_data[1] !== 8'h03) begin n_fail++; $display("FAIL t3_final_cfg: got %h want 03", h_data[1]); end
`ifdef RX_ALIGN_PASS_MAP_EN
    n_checks++; if (pass_map !== 64'h0000_003C_0000_003C) begin n_fail++; $display("FAIL t3_map: got %h want 0000003c0000003c", pass_map); end
`endif
  endtask

  task automatic test_no_cross_edge;
    int cyc;
    logic [2*STEPS-1:0] m0;
    set_pattern(32'hC000_0000, 32'h0000_0001, 1'b0, 8'd0);
    run_scan(0, cyc, m0);
    n_checks++; if (cyc !== SCAN_CYCLES) begin n_fail++; $display("FAIL t4_busy_cycles: got %0d want %0d", cyc, SCAN_CYCLES); end
    n_checks++; if (fail !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL t4_fail: got done=%b fail=%b want 0/1", done, fail); end
    n_checks++; if (best_dly !== 5'd0 || best_edge !== 1'b0) begin n_fail++; $display("FAIL t4_best: got %0d/%b want 0/0", best_dly, best_edge); end
    n_checks++; if (h_addr[0] !== 0 || h_addr[1] !== 7 || h_data[1] !== 8'h00 || h_addr[2] !== 2 || h_data[2] !== 8'h04) begin
      n_fail++; $display("FAIL t4_final_writes: got %0d %0d:%h %0d:%h want 0 7:00 2:04", h_addr[0], h_addr[1], h_data[1], h_addr[2], h_data[2]); end
`ifdef RX_ALIGN_PASS_MAP_EN
    n_checks++; if (pass_map !== 64'h0000_0001_C000_0000) begin n_fail++; $display("FAIL t4_map: got %h want 00000001c0000000", pass_map); end
`endif
  endtask

  task automatic test_conf_and_busy_start;
    int cyc, c0, cb0, eb0;
    logic [2*STEPS-1:0] m0;
    conf_no8 = 1'b1; conf_inv = 1'b1;
    set_pattern(32'h0003_FC00, 32'h0, 1'b0, 8'd0);
    c0 = cfg_cnt; cb0 = cfg_bad; eb0 = en_bad;
    run_scan(20, cyc, m0);
    n_checks++; if (cyc !== SCAN_CYCLES) begin n_fail++; $display("FAIL t5_busy_cycles: got %0d want %0d", cyc, SCAN_CYCLES); end
    n_checks++; if (cfg_cnt - c0 !== 65) begin n_fail++; $display("FAIL t5_cfg_writes: got %0d want 65", cfg_cnt - c0); end
    n_checks++; if (cfg_bad != cb0 || en_bad != eb0) begin n_fail++; $display("FAIL t5_conf_bits: got cfg=%0d en=%0d bad writes want 0", cfg_bad-cb0, en_bad-eb0); end
    n_checks++; if (h_data[1] !== 8'h4D || h_data[2] !== 8'h06 || best_dly !== 5'd13) begin n_fail++; $display("FAIL t5_final: got cfg=%h en=%h dly=%0d want 4d 06 13", h_data[1], h_data[2], best_dly); end
    conf_no8 = 1'b0; conf_inv = 1'b0;
  endtask

  task automatic test_reset_mid_scan;
    int cyc, c0, w0, guard;
    logic [2*STEPS-1:0] m0;
    set_pattern(32'h0003_FC00, 32'h0, 1'b0, 8'd0);
    c0 = cfg_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    guard = 0;
    while (cfg_cnt - c0 < 6 && guard < 200) begin guard++; tick; end
    n_checks++; if (guard >= 200 || cfg_log[(c0+5) % 1024] !== 8'h05) begin n_fail++; $display("FAIL t6_reach_tap5: got guard=%0d cfg=%h want cfg 05", guard, cfg_log[(c0+5) % 1024]); end
    tick;
    tick;
    rst = 1'b1;
    tick;
    n_checks++; if (busy !== 1'b0 || bus.M_BUS_WR !== 1'b0 || bus.M_BUS_RD !== 1'b0 || bus.M_BUS_ADD !== '0) begin
      n_fail++; $display("FAIL t6_reset_stop: got busy=%b wr=%b rd=%b add=%h want 0", busy, bus.M_BUS_WR, bus.M_BUS_RD, bus.M_BUS_ADD); end
    rst = 1'b0;
    w0 = wr_cnt;
    repeat (5) tick;
    n_checks++; if (wr_cnt != w0 || pass_map !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL t6_idle_after_reset: got writes=%0d map=%h done=%b want 0", wr_cnt - w0, pass_map, done); end
    c0 = cfg_cnt;
    run_scan(0, cyc, m0);
    n_checks++; if (cfg_log[c0 % 1024] !== 8'h00 || m0 !== '0) begin n_fail++; $display("FAIL t6_restart: got first cfg=%h map=%h want 00/0", cfg_log[c0 % 1024], m0); end
    n_checks++; if (cyc !== SCAN_CYCLES || done !== 1'b1 || best_dly !== 5'd13) begin n_fail++; $display("FAIL t6_rescan: got cyc=%0d done=%b dly=%0d want %0d 1 13", cyc, done, best_dly, SCAN_CYCLES); end
  endtask

  initial begin
    test_reset;
    test_single_window;
    test_edge1_window;
    test_tie;
    test_no_cross_edge;
    test_conf_and_busy_start;
    test_reset_mid_scan;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tjmono2_rx_align_ctrl.md
Name: tjmono2_rx_align_ctrl

Overview:
Bus-master sequencer that finds a working sampling phase for one tjmono2 RX channel. It sweeps the channel's sampling edge (0/1) and data delay (0..DLY_STEPS-1) by writing the RX core register map. For each setting it checks link lock and the 8b10b decoder error count. It then applies the centre of the widest passing window. It sits between the firmware bus and one RX core register slave, and is multiplexed onto that slave's bus port by the top level.

Parameters:
ABUSWIDTH, 32, width of M_BUS_ADD
DLY_STEPS, 32, delay taps scanned per edge (max 32; delay field is 5 bits)
SETTLE_CYCLES, 1024, BUS_CLK cycles waited after enabling RX before sampling status
MIN_WINDOW, 3, minimum consecutive passing taps for success

Ports:
BUS_CLK  in  1  single clock for all logic
BUS_RST  in  1  synchronous active-high reset
START  in  1  one-cycle pulse; starts a scan when idle
CONF_INVERT  in  1  value for RX reg2 bit1 on every enable write
CONF_NO_8B10B  in  1  value for RX reg7 bit6 on every reg7 write
BUSY  out  1  high from accepted START until DONE/FAIL set
DONE  out  1  sticky; scan succeeded; cleared by next START
FAIL  out  1  sticky; no window >= MIN_WINDOW; cleared by next START
BEST_DLY  out  5  delay applied at end of scan
BEST_EDGE  out  1  sampling edge applied at end of scan
M_BUS_ADD  out  ABUSWIDTH  address to RX core
M_BUS_DATA_OUT  out  8  write data to RX core
M_BUS_DATA_IN  in  8  read data from RX core; valid one cycle after M_BUS_RD
M_BUS_WR  out  1  one-cycle write strobe
M_BUS_RD  out  1  one-cycle read strobe
PASS_MAP  out  2*DLY_STEPS  per-tap pass bits; [DLY_STEPS-1:0] = edge 0, upper half = edge 1

Behaviour:
- Reset: all outputs 0; state IDLE. BUSY, DONE, FAIL, strobes, BEST_* and PASS_MAP are 0.
- Reset mid-scan: strobes are deasserted on the next edge and the scan is abandoned. RX registers are left as last written.
- START while BUSY: ignored. START in IDLE: clears DONE/FAIL, sets BUSY the next cycle, and zeroes the edge, delay and window trackers.
- Per tap, states in order, one strobe per state, no idle cycles between strobes:
  - RST_WR: write addr 0, data 0x00. This soft reset clears the RX config and error counters.
  - CFG_WR: write addr 7, data {0, CONF_NO_8B10B, edge, dly}.
  - EN_WR: write addr 2, data {5'b0, 1, CONF_INVERT, 0}.
  - SETTLE: wait exactly SETTLE_CYCLES cycles.
  - RD_RDY: pulse RD at addr 2. RD_RDY_W: capture M_BUS_DATA_IN[0] as ready.
  - RD_ERR: pulse RD at addr 5. RD_ERR_W: capture error count.
  - EVAL: pass = ready & (err == 0).
- EVAL window tracking:
  - On pass, extend the current run; record run_start if the run is new.
  - A run ends on a fail, or after tap DLY_STEPS-1 of each edge. Runs never wrap across edges or across the delay range.
  - When a run ends, replace the best run only if its length > best_len (strict). Ties therefore keep edge 0 and the lower delay.
- Tap iteration: dly increments after each EVAL. After dly = DLY_STEPS-1, edge goes 0 -> 1 and dly returns to 0. After edge 1 / last tap, go to APPLY.
- APPLY:
  - If best_len >= MIN_WINDOW: BEST_DLY = best_start + (best_len-1)>>1 (integer, floor), BEST_EDGE = best_edge. Perform RST_WR, CFG_WR, EN_WR with these values, then set DONE and clear BUSY in the same cycle.
  - Else: BEST_DLY = 0, BEST_EDGE = 0. Write RST, CFG (dly 0, edge 0), EN, then set FAIL and clear BUSY.
- M_BUS_ADD and M_BUS_DATA_OUT hold 0 whenever no strobe is active.
- Per-tap latency: 3 + SETTLE_CYCLES + 4 + 1 cycles. Full scan latency: 2*DLY_STEPS*(SETTLE_CYCLES+8) + 3, plus 1 cycle from START to BUSY.
- Error count is compared as a full 8-bit value; any non-zero count fails the tap.

Optional Feature:
RX_ALIGN_PASS_MAP_EN
- Defined: PASS_MAP bit {edge, dly} is set at EVAL to that tap's pass result. PASS_MAP is cleared on START and on reset, and holds its value after DONE/FAIL.
- Undefined: PASS_MAP is tied to all zeros and no map registers are synthesised.

Test Plan:
1. Bus model: edge 0 taps 10..17 pass, all others fail, START -> 64 taps scanned; final writes addr7 = 0x0D (dly 13, edge 0); DONE=1, FAIL=0, BEST_DLY=13.
2. Edge 0 taps 4..6 pass and edge 1 taps 20..27 pass -> BEST_EDGE=1, BEST_DLY=23, addr7 = 0x37; PASS_MAP (macro on) = bits 4..6 and 52..59.
3. Equal windows: edge 0 taps 2..5 and edge 1 taps 2..5 pass -> edge 0 wins; BEST_DLY=3; ready=1 with err=1 on every tap counts as fail.
4. Only taps 30..31 of edge 0 and 0 of edge 1 pass, MIN_WINDOW=3 -> no cross-edge merge; FAIL=1, final addr7 write 0x00, then addr2 write 0x04.
5. With CONF_NO_8B10B=1 and CONF_INVERT=1, check every addr7 write has bit6=1 and every addr2 write = 0x06. A second START while BUSY has no effect.
6. BUS_RST asserted during SETTLE of tap 5 -> next cycle BUSY=0 and no strobes. A new START restarts at edge 0, dly 0 with PASS_MAP cleared.
